// File: rtl/branch_resolve_pkg.sv
// Shared scalar types and the decode-stage branch kinds and resolver states.
package common;
  typedef logic        u1;
  typedef logic [63:0] u64;
endpackage

package decode_pkg;
  import common::*;

  typedef enum logic [2:0] {
    B_NONE = 3'd0,
    B_EQ   = 3'd1,
    B_NE   = 3'd2,
    B_LT   = 3'd3,
    B_GE   = 3'd4,
    B_LTU  = 3'd5,
    B_GEU  = 3'd6
  } branch_t;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } resolve_state_t;

  localparam u64 PC_STEP = 64'd4;
endpackage

// File: rtl/branch_resolve_target.sv
// Combinational target computation and prediction compare for one instruction.
module branch_target
  import common::*;
  import decode_pkg::*;
(
  input  u64      pc,
  input  u64      imm,
  input  u64      rs1,
  input  branch_t branch_type,
  input  u1       branch_taken,
  input  u1       jump,
  input  u1       jalr,
  input  u1       pred_taken,
  input  u64      pred_target,
  output u1       is_ctrl,
  output u64      target,
  output u1       actual_taken,
  output u64      actual_next,
  output u1       mispredict
);

  u64 sum;
  u1  is_branch;
  u1  use_rs1;

  always_comb begin
    is_branch    = (branch_type != B_NONE);
    use_rs1      = jump && jalr;
    is_ctrl      = is_branch || jump;
    sum          = (use_rs1 ? rs1 : pc) + imm;
    target       = use_rs1 ? {sum[63:1], 1'b0} : sum;
    actual_taken = jump || (is_branch && branch_taken);
    actual_next  = actual_taken ? target : pc + PC_STEP;
    // A non-control instruction predicted taken falls out naturally as a
    // direction mismatch, redirecting to pc+4.
    mispredict   = (pred_taken != actual_taken) ||
                   (actual_taken && (pred_target != target));
  end

endmodule

// File: rtl/branch_resolve.sv
// Execute-stage branch resolver: issues fetch redirects on mispredict and
// predictor update pulses for every resolved control instruction.
//   state | meaning
//   IDLE  | accepting instructions
//   HOLD  | redirect pending, wrong-path instructions ignored
module branch_resolve
  import common::*;
  import decode_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [63:0]      in_pc,
  input  logic [63:0]      in_imm,
  input  logic [63:0]      in_rs1,
  input  branch_t          in_branch_type,
  input  logic             in_branch_taken,
  input  logic             in_jump,
  input  logic             in_jalr,
  input  logic             in_pred_taken,
  input  logic [63:0]      in_pred_target,
  output logic             redirect_valid,
  input  logic             redirect_ready,
  output logic [63:0]      redirect_pc,
  output logic             flush,
  output logic             upd_valid,
  output logic [63:0]      upd_pc,
  output logic             upd_taken,
  output logic [63:0]      upd_target,
  output logic [CNT_W-1:0] mispred_cnt
);

  resolve_state_t   state_q, state_d;
  u64               redirect_pc_q, redirect_pc_d;
  u1                flush_q, flush_d;
  u1                upd_valid_q, upd_valid_d;
  u64               upd_pc_q, upd_pc_d;
  u1                upd_taken_q, upd_taken_d;
  u64               upd_target_q, upd_target_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  u1  is_ctrl, actual_taken, mispredict, accept;
  u64 target, actual_next;

  branch_target u_target (
    .pc           (in_pc),
    .imm          (in_imm),
    .rs1          (in_rs1),
    .branch_type  (in_branch_type),
    .branch_taken (in_branch_taken),
    .jump         (in_jump),
    .jalr         (in_jalr),
    .pred_taken   (in_pred_taken),
    .pred_target  (in_pred_target),
    .is_ctrl      (is_ctrl),
    .target       (target),
    .actual_taken (actual_taken),
    .actual_next  (actual_next),
    .mispredict   (mispredict)
  );

  always_comb begin
    state_d       = state_q;
    redirect_pc_d = redirect_pc_q;
    flush_d       = 1'b0;
    upd_valid_d   = 1'b0;
    upd_pc_d      = upd_pc_q;
    upd_taken_d   = upd_taken_q;
    upd_target_d  = upd_target_q;
    cnt_d         = cnt_q;
    accept        = in_valid && (state_q == IDLE);

    case (state_q)
      IDLE: begin
        if (accept && is_ctrl) begin
          upd_valid_d  = 1'b1;
          upd_pc_d     = in_pc;
          upd_taken_d  = actual_taken;
          upd_target_d = target;
        end
        if (accept && mispredict) begin
          state_d       = HOLD;
          redirect_pc_d = actual_next;
          flush_d       = 1'b1;
          if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HOLD: begin
        if (redirect_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q       <= IDLE;
      redirect_pc_q <= '0;
      flush_q       <= 1'b0;
      upd_valid_q   <= 1'b0;
      upd_pc_q      <= '0;
      upd_taken_q   <= 1'b0;
      upd_target_q  <= '0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      redirect_pc_q <= redirect_pc_d;
      flush_q       <= flush_d;
      upd_valid_q   <= upd_valid_d;
      upd_pc_q      <= upd_pc_d;
      upd_taken_q   <= upd_taken_d;
      upd_target_q  <= upd_target_d;
      cnt_q         <= cnt_d;
    end
  end

  assign in_ready       = (state_q == IDLE);
  assign redirect_valid = (state_q == HOLD);
  assign redirect_pc    = redirect_pc_q;
  assign flush          = flush_q;
  assign upd_valid      = upd_valid_q;
  assign upd_pc         = upd_pc_q;
  assign upd_taken      = upd_taken_q;
  assign upd_target     = upd_target_q;
  assign mispred_cnt    = cnt_q;

endmodule

// File: tb/tb_branch_resolve.sv
// Directed bench for branch_resolve; a second CNT_W=2 instance checks saturation.
module tb_branch_resolve;
  import decode_pkg::*;

  logic        clk = 1'b0;
  logic        resetn;
  logic        in_valid;
  logic [63:0] in_pc, in_imm, in_rs1, in_pred_target;
  branch_t     in_branch_type;
  logic        in_branch_taken, in_jump, in_jalr, in_pred_taken;
  logic        redirect_ready;

  logic        in_ready, redirect_valid, flush, upd_valid, upd_taken;
  logic [63:0] redirect_pc, upd_pc, upd_target;
  logic [31:0] mispred_cnt;

  logic        s_in_ready, s_redirect_valid, s_flush, s_upd_valid, s_upd_taken;
  logic [63:0] s_redirect_pc, s_upd_pc, s_upd_target;
  logic [1:0]  s_mispred_cnt;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  branch_resolve #(.CNT_W(32)) dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_imm(in_imm), .in_rs1(in_rs1),
    .in_branch_type(in_branch_type), .in_branch_taken(in_branch_taken),
    .in_jump(in_jump), .in_jalr(in_jalr), .in_pred_taken(in_pred_taken),
    .in_pred_target(in_pred_target), .redirect_valid(redirect_valid),
    .redirect_ready(redirect_ready), .redirect_pc(redirect_pc), .flush(flush),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target), .mispred_cnt(mispred_cnt)
  );

  branch_resolve #(.CNT_W(2)) dut_sat (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_pc(in_pc), .in_imm(in_imm), .in_rs1(in_rs1),
    .in_branch_type(in_branch_type), .in_branch_taken(in_branch_taken),
    .in_jump(in_jump), .in_jalr(in_jalr), .in_pred_taken(in_pred_taken),
    .in_pred_target(in_pred_target), .redirect_valid(s_redirect_valid),
    .redirect_ready(redirect_ready), .redirect_pc(s_redirect_pc), .flush(s_flush),
    .upd_valid(s_upd_valid), .upd_pc(s_upd_pc), .upd_taken(s_upd_taken),
    .upd_target(s_upd_target), .mispred_cnt(s_mispred_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [63:0] pc, input logic [63:0] imm,
                       input logic [63:0] rs1, input branch_t bt, input logic bk,
                       input logic j, input logic jr, input logic pt,
                       input logic [63:0] ptgt);
    in_valid = v; in_pc = pc; in_imm = imm; in_rs1 = rs1; in_branch_type = bt;
    in_branch_taken = bk; in_jump = j; in_jalr = jr; in_pred_taken = pt;
    in_pred_target = ptgt;
  endtask

  task automatic idle_in();
    drive(1'b0, 64'h0, 64'h0, 64'h0, B_NONE, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
  endtask

  initial begin
    resetn = 1'b0;
    redirect_ready = 1'b0;
    idle_in();
    tick();
    tick();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_redirect_valid", redirect_valid, 0);
    chk("rst_flush", flush, 0);
    chk("rst_upd_valid", upd_valid, 0);
    chk("rst_redirect_pc", redirect_pc, 0);
    chk("rst_upd_target", upd_target, 0);
    chk("rst_cnt", mispred_cnt, 0);
    chk("rst_cnt_sat", s_mispred_cnt, 0);

    // beq taken, correctly predicted
    resetn = 1'b1;
    drive(1'b1, 64'h1000, 64'h20, 64'h0, B_EQ, 1'b1, 1'b0, 1'b0, 1'b1, 64'h1020);
    tick();
    chk("beq_redirect_valid", redirect_valid, 0);
    chk("beq_flush", flush, 0);
    chk("beq_upd_valid", upd_valid, 1);
    chk("beq_upd_pc", upd_pc, 64'h1000);
    chk("beq_upd_taken", upd_taken, 1);
    chk("beq_upd_target", upd_target, 64'h1020);
    chk("beq_cnt", mispred_cnt, 0);
    chk("beq_in_ready", in_ready, 1);

    // back-to-back: bne not taken but predicted taken
    drive(1'b1, 64'h2000, 64'h40, 64'h0, B_NE, 1'b0, 1'b0, 1'b0, 1'b1, 64'h2040);
    tick();
    chk("bne_redirect_valid", redirect_valid, 1);
    chk("bne_redirect_pc", redirect_pc, 64'h2004);
    chk("bne_flush", flush, 1);
    chk("bne_cnt", mispred_cnt, 1);
    chk("bne_upd_valid", upd_valid, 1);
    chk("bne_upd_taken", upd_taken, 0);
    chk("bne_in_ready", in_ready, 0);

    // wrong-path instruction offered while redirect stalls
    drive(1'b1, 64'h5000, 64'h0, 64'h0, B_NONE, 1'b0, 1'b0, 1'b0, 1'b1, 64'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_redirect_valid", redirect_valid, 1);
      chk("hold_redirect_pc", redirect_pc, 64'h2004);
      chk("hold_flush", flush, 0);
      chk("hold_upd_valid", upd_valid, 0);
      chk("hold_in_ready", in_ready, 0);
      chk("hold_cnt", mispred_cnt, 1);
    end
    redirect_ready = 1'b1;
    tick();
    chk("release_redirect_valid", redirect_valid, 0);
    chk("release_in_ready", in_ready, 1);
    chk("release_cnt", mispred_cnt, 1);
    chk("release_upd_valid", upd_valid, 0);
    redirect_ready = 1'b0;

    // jalr: (0x3001+0x10) with bit0 cleared = 0x3010
    drive(1'b1, 64'h3000, 64'h10, 64'h3001, B_NONE, 1'b0, 1'b1, 1'b1, 1'b1, 64'h3010);
    tick();
    chk("jalr_ok_redirect_valid", redirect_valid, 0);
    chk("jalr_ok_upd_target", upd_target, 64'h3010);
    chk("jalr_ok_upd_taken", upd_taken, 1);
    chk("jalr_ok_cnt", mispred_cnt, 1);
    redirect_ready = 1'b1;
    drive(1'b1, 64'h3000, 64'h10, 64'h3001, B_NONE, 1'b0, 1'b1, 1'b1, 1'b1, 64'h3014);
    tick();
    chk("jalr_bad_redirect_valid", redirect_valid, 1);
    chk("jalr_bad_redirect_pc", redirect_pc, 64'h3010);
    chk("jalr_bad_cnt", mispred_cnt, 2);
    idle_in();
    tick();
    chk("jalr_release", redirect_valid, 0);

    // non-control, predicted not taken then taken
    redirect_ready = 1'b0;
    drive(1'b1, 64'h4000, 64'h0, 64'h0, B_NONE, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
    tick();
    chk("nc_ok_upd_valid", upd_valid, 0);
    chk("nc_ok_redirect_valid", redirect_valid, 0);
    drive(1'b1, 64'h4000, 64'h0, 64'h0, B_NONE, 1'b0, 1'b0, 1'b0, 1'b1, 64'h4100);
    tick();
    chk("nc_bad_redirect_pc", redirect_pc, 64'h4004);
    chk("nc_bad_upd_valid", upd_valid, 0);
    chk("nc_bad_cnt", mispred_cnt, 3);
    redirect_ready = 1'b1;
    idle_in();
    tick();
    redirect_ready = 1'b0;

    // jal whose target wraps around 2^64
    drive(1'b1, 64'hFFFF_FFFF_FFFF_FFF0, 64'h20, 64'h0, B_NONE, 1'b0, 1'b1, 1'b0, 1'b1, 64'h10);
    tick();
    chk("jal_wrap_redirect_valid", redirect_valid, 0);
    chk("jal_wrap_upd_target", upd_target, 64'h10);

    // blt taken backwards, predicted not taken
    drive(1'b1, 64'h1000, 64'hFFFF_FFFF_FFFF_FFF8, 64'h0, B_LT, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0);
    tick();
    chk("blt_redirect_pc", redirect_pc, 64'hFF8);
    chk("blt_cnt", mispred_cnt, 4);
    idle_in();

    // reset while holding
    resetn = 1'b0;
    tick();
    chk("rst_hold_redirect_valid", redirect_valid, 0);
    chk("rst_hold_cnt", mispred_cnt, 0);
    chk("rst_hold_in_ready", in_ready, 1);
    chk("rst_hold_flush", flush, 0);
    resetn = 1'b1;

    // five mispredicts: 2-bit counter saturates at 3
    for (int k = 0; k < 5; k++) begin
      redirect_ready = 1'b0;
      drive(1'b1, 64'h6000, 64'h0, 64'h0, B_NONE, 1'b0, 1'b0, 1'b0, 1'b1, 64'h0);
      tick();
      redirect_ready = 1'b1;
      idle_in();
      tick();
    end
    chk("sat_cnt_w2", s_mispred_cnt, 3);
    chk("sat_cnt_w32", mispred_cnt, 5);
    chk("sat_redirect_valid", redirect_valid, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/branch_resolve.md
BRANCH_RESOLVE -- requirements
Module: branch_resolve

Interface
REQ-001 SHALL have parameter: CNT_W, 32, width of mispredict counter.
REQ-002 SHALL have ports (clock and reset first):
clk  in  1  single clock, all state on rising edge
resetn  in  1  synchronous active-low reset
in_valid  in  1  execute-stage instruction valid
in_ready  out  1  resolver can accept instruction
in_pc  in  64  instruction PC
in_imm  in  64  sign-extended immediate
in_rs1  in  64  rs1 value (jalr base)
in_branch_type  in  branch_t  conditional branch kind, B_NONE if not a branch
in_branch_taken  in  1  condition result from branch compare unit
in_jump  in  1  unconditional jal/jalr
in_jalr  in  1  jump is jalr (valid only with in_jump)
in_pred_taken  in  1  fetch-stage prediction taken
in_pred_target  in  64  fetch-stage predicted target
redirect_valid  out  1  fetch redirect request
redirect_ready  in  1  fetch accepts redirect
redirect_pc  out  64  corrected fetch PC
flush  out  1  one-cycle kill of younger in-flight instructions
upd_valid  out  1  predictor update pulse
upd_pc  out  64  resolved instruction PC
upd_taken  out  1  actual direction
upd_target  out  64  actual taken target
mispred_cnt  out  CNT_W  saturating mispredict count

Function
REQ-003 SHALL accept an instruction when in_valid && in_ready; control instruction = in_branch_type != B_NONE or in_jump.
REQ-004 SHALL compute target = pc+imm (branch, jal) or (rs1+imm) with bit0 cleared (jalr), 64-bit modulo wrap.
REQ-005 SHALL compute actual_taken = in_jump or (branch && in_branch_taken); actual_next = actual_taken ? target : pc+4.
REQ-006 SHALL flag mispredict when pred_taken != actual_taken, or actual_taken && pred_target != target.
REQ-007 SHALL flag mispredict for non-control instruction with pred_taken=1, redirect_pc = pc+4.
REQ-008 SHALL implement FSM IDLE, HOLD; IDLE: in_ready=1; HOLD: in_ready=0.
REQ-009 SHALL, on accepted mispredict in cycle N, in N+1: enter HOLD, redirect_valid=1, redirect_pc=actual_next, flush=1 for exactly that cycle.
REQ-010 SHALL hold redirect_valid and redirect_pc stable in HOLD until redirect_ready=1; return to IDLE the following cycle.
REQ-011 SHALL ignore in_valid while in HOLD (wrong-path), no update, no count.
REQ-012 SHALL pulse upd_valid in N+1 for each accepted control instruction, with upd_pc/upd_taken/upd_target registered from cycle N; not for non-control.
REQ-013 SHALL increment mispred_cnt by 1 per accepted mispredict, saturating at all-ones.
REQ-014 SHALL treat redirect_ready as don't-care when redirect_valid=0.
REQ-015 SHALL allow back-to-back correctly predicted instructions every cycle, no bubble.

Reset
REQ-016 SHALL on resetn=0 at a clock edge: state IDLE, redirect_valid=0, flush=0, upd_valid=0, redirect_pc=0, upd_*=0, mispred_cnt=0.
REQ-017 SHALL abandon a pending redirect on reset mid-HOLD; redirect_valid=0 next cycle.

Structure
REQ-018 SHALL use branch_t from decode_pkg and u1/u64 from common; add resolve_state_t (IDLE, HOLD) to decode_pkg.
REQ-019 SHALL be a single module; target/compare logic may be a combinational sub-module branch_target.

Verification
REQ-020 beq taken, pc=0x1000, imm=0x20, pred_taken=1, pred_target=0x1020 -> no redirect, upd_valid=1, upd_target=0x1020, cnt=0.
REQ-021 bne not-taken, pc=0x2000, pred_taken=1 -> N+1 redirect_pc=0x2004, flush=1 one cycle, cnt=1.
REQ-022 jalr rs1=0x3001, imm=0x10, pred_target=0x3010 -> target 0x3010, no redirect; pred_target 0x3014 -> redirect_pc=0x3010.
REQ-023 mispredict, redirect_ready=0 for 3 cycles -> redirect_valid/pc stable 3 cycles, in_ready=0, in_valid ignored; ready=1 -> IDLE next cycle.
REQ-024 resetn=0 during HOLD -> redirect_valid=0, cnt=0 next cycle; CNT_W=2 with 5 mispredicts -> cnt=3.
